bp_cfg_loader: RTL

- Post-reset configuration sequencer that consumes the per-build processor parameters (core count, boot PC, coherence mode) and programs each core's config registers over a point-to-point config write channel.
- Sits between the top-level reset/boot controller and the per-tile config slaves.
- Holds all cores frozen while programming them, then unfreezes every core.
- Flow-controls writes with a credit counter and reports completion once every write has been acknowledged.

---
 rtl/bp_cfg_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bp_cfg_loader.sv
// Post-reset configuration sequencer: freezes and programs every core's config
// registers over a credit-flow-controlled write channel, then unfreezes all cores.
module bp_cfg_loader #(
    parameter int unsigned num_core_p       = 1,
    parameter int unsigned cfg_addr_width_p = 16,
    parameter int unsigned cfg_data_width_p = 64,
    parameter int unsigned vaddr_width_p    = 39,
    parameter int unsigned credits_p        = 4
) (
    input  logic                                                   clk_i,
    input  logic                                                   reset_n_i,
    input  logic                                                   start_i,
    input  logic [vaddr_width_p-1:0]                               boot_pc_i,
    input  logic [1:0]                                             cce_mode_i,
    output logic                                                   cfg_v_o,
    input  logic                                                   cfg_ready_i,
    output logic [((num_core_p > 1) ? $clog2(num_core_p) : 1)-1:0] cfg_dst_o,
    output logic [cfg_addr_width_p-1:0]                            cfg_addr_o,
    output logic [cfg_data_width_p-1:0]                            cfg_data_o,
    input  logic                                                   cfg_resp_v_i,
    output logic                                                   busy_o,
    output logic                                                   done_o,
    output logic                                                   err_o
);

    localparam int unsigned DST_W  = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int unsigned CRD_W  = $clog2(credits_p + 1);
    localparam int unsigned ADDR_W = cfg_addr_width_p;
    localparam int unsigned DATA_W = cfg_data_width_p;
    localparam int unsigned VA_W   = vaddr_width_p;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CFG   = 3'd1;
    localparam logic [2:0] S_UNFR  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [DST_W-1:0] core_q, core_d;
    logic [1:0]       step_q, step_d;
    logic [CRD_W-1:0] cnt_q, cnt_d;
    logic [VA_W-1:0]  pc_q, pc_d;
    logic [1:0]       mode_q, mode_d;
    logic             v_q, v_d;
    logic [DST_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             xfer;
    logic             last_core;

    assign xfer      = v_q & cfg_ready_i;
    assign last_core = (core_q == DST_W'(num_core_p - 1));

    // Next-state, credit accounting and registered channel payload
    always_comb begin
        state_d = state_q;
        core_d  = core_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        mode_d  = mode_q;
        err_d   = err_q;
        v_d     = 1'b0;
        dst_d   = '0;
        addr_d  = '0;
        data_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        // A response with nothing outstanding (and no write landing) is a protocol error
        if (xfer && !cfg_resp_v_i) begin
            cnt_d = cnt_q + CRD_W'(1);
        end else if (!xfer && cfg_resp_v_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - CRD_W'(1);
            else             err_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_CFG;
                    core_d  = '0;
                    step_d  = '0;
                    pc_d    = boot_pc_i;
                    mode_d  = cce_mode_i;
                end
            end
            S_CFG: begin
                if (xfer) begin
                    if (step_q == 2'd3) begin
                        step_d = '0;
                        if (last_core) begin
                            core_d  = '0;
                            state_d = S_UNFR;
                        end else begin
                            core_d = core_q + DST_W'(1);
                        end
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            S_UNFR: begin
                if (xfer) begin
                    if (last_core) begin
                        core_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        core_d = core_q + DST_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Payload only moves when the counters move, so it holds while stalled
        v_d = ((state_d == S_CFG) || (state_d == S_UNFR)) && (cnt_d < CRD_W'(credits_p));
        if (v_d) begin
            dst_d = core_d;
            if (state_d == S_CFG) begin
                addr_d = ADDR_W'({step_d, 2'b00});
                case (step_d)
                    2'd0:    data_d = DATA_W'(1);
                    2'd1:    data_d = DATA_W'(core_d);
                    2'd2:    data_d = DATA_W'(pc_d);
                    default: data_d = DATA_W'(mode_d);
                endcase
            end
        end
        busy_d = (state_d == S_CFG) || (state_d == S_UNFR) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            core_q  <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            pc_q    <= '0;
            mode_q  <= '0;
            v_q     <= 1'b0;
            dst_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            mode_q  <= mode_d;
            v_q     <= v_d;
            dst_q   <= dst_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cfg_v_o    = v_q;
    assign cfg_dst_o  = dst_q;
    assign cfg_addr_o = addr_q;
    assign cfg_data_o = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
